// File: rtl/handshake_pkg.sv
// Shared definitions for the valid/ready handshake blocks.
// Holds the default data width and the occupancy-count width helper.
package handshake_pkg;

  localparam int unsigned HS_DATA_BITS = 8;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned count_bits(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Register-array storage for the handshake receive FIFO.
// One synchronous write port and one asynchronous read port.
module handshake_fifo_mem
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_BITS = HS_DATA_BITS,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  // No reset on the array: contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_rx_fifo.sv
// Slave end of a valid/ready link feeding a first-word-fall-through FIFO.
// Pointers, occupancy, ready and the sticky underflow flag live here.
module handshake_rx_fifo
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_BITS = HS_DATA_BITS,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_BITS  = count_bits(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 rd_en,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [CNT_BITS-1:0]  count,
  output logic                 rd_underflow
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_nxt;
  logic                ready_q;
  logic                underflow_q;
  logic                empty;
  logic                accept;
  logic                pop;

  assign empty  = (count_q == '0);
  assign accept = s_valid && ready_q;
  assign pop    = rd_en && !empty;

  always_comb begin
    count_nxt = count_q;
    case ({accept, pop})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  // Ready is registered from the next occupancy so it never depends
  // combinationally on s_valid or rd_en, and stays low through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_nxt;
      ready_q <= (count_nxt != FULL_CNT);
      if (rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  handshake_fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (PTR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (s_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign s_ready      = ready_q;
  assign rd_valid     = !empty;
  assign count        = count_q;
  assign rd_underflow = underflow_q;

endmodule

// File: doc/handshake_rx_fifo.md
# handshake_rx_fifo

Synthesizable receiving end of the team's valid/ready handshake: acts as the slave of a handshake link and buffers accepted beats in a small first-word-fall-through FIFO. The local consumer drains beats through a simple read-enable port. It replaces the behavioural slave wherever a real design terminates a handshake stream, and is checked against the existing handshake master driver.

## Interface
Parameters:
- DATA_BITS, 8, width of handshake data and read data
- DEPTH, 4, FIFO entries; power of two, >= 2
- CNT_BITS, $clog2(DEPTH+1), width of the occupancy count; derived, not overridden

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  handshake valid from master
- s_ready  output  1  handshake ready to master
- s_data  input  DATA_BITS  handshake data
- rd_en  input  1  consumer pops head entry
- rd_valid  output  1  head entry present (FIFO not empty)
- rd_data  output  DATA_BITS  head entry, valid when rd_valid
- count  output  CNT_BITS  current occupancy, 0..DEPTH
- rd_underflow  output  1  sticky: rd_en seen while empty; cleared only by rst

## Operation
- Beat accepted on a rising edge where s_valid && s_ready; s_data written at write pointer, wr_ptr increments.
- Pop on a rising edge where rd_en && rd_valid; rd_ptr increments. rd_en while empty: no state change except setting rd_underflow.
- s_ready = (count != DEPTH). It is a function of registered state only; no combinational path from rd_en or s_valid to s_ready.
- At full, a beat is not accepted even if rd_en pops in the same cycle; s_ready rises the cycle after the pop.
- Simultaneous accept and pop (not full, not empty): count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from count, not pointer compare.
- rd_data = mem[rd_ptr]; first-word fall-through, no read latency.
- s_data is ignored when no accept occurs; stored data is never modified while resident.
- Beats are delivered in acceptance order, none dropped or duplicated.

## Timing
- Reset values: s_ready=0 while rst high, 1 the first cycle after rst deasserts; rd_valid=0; count=0; rd_underflow=0; rd_data don't-care. Reset mid-operation discards all contents; pointers return to 0 on the same edge.
- Accept-to-rd_valid latency: 1 cycle (beat accepted at edge N, rd_valid/rd_data visible after edge N).
- Pop-to-s_ready latency when full: 1 cycle.
- Sustained throughput: one beat per cycle in and out when neither full nor empty.
- count updates on the same edge as the accept/pop it reflects: +1 accept only, -1 pop only, 0 both or neither.

## Structure
- Package handshake_pkg: a function returning count width for a depth, and a localparam default DATA_BITS=8 shared with the handshake interface; no block-specific types.
- One sub-module natural: handshake_fifo_mem (DEPTH x DATA_BITS register array, one write port, one asynchronous read port). Control (pointers, count, ready, underflow) stays in handshake_rx_fifo.
- The bench connects s_* to the handshake interface signals valid/ready/data and drives with the existing master driver.

## Test plan
- Reset then two master beats 8'hA5, 8'hC4, rd_en held 0 -> count 0->1->2, rd_valid=1, rd_data=8'hA5; s_ready stays 1.
- Fill DEPTH=4 with 8'h01..8'h04, rd_en=0 -> count=4, s_ready=0; a fifth beat 8'h05 held by master until one pop, then accepted the cycle after; read order 01,02,03,04,05.
- Continuous stream 8'h10..8'h1F with rd_en=1 every cycle -> one beat per cycle, count never exceeds 1, output order matches input.
- rd_en=1 while empty after reset -> count stays 0, rd_underflow=1 and remains 1 after subsequent normal traffic until rst.
- Load 3 beats, assert rst for one cycle mid-stream -> next cycle count=0, rd_valid=0, rd_underflow=0; following beat 8'hA5 reads back as first entry.
- Random s_valid/rd_en (50% each) over 1000 beats with a scoreboard -> no loss, duplication or reorder; pointers wrap correctly; count always matches scoreboard depth.
